// File: rtl/pipeline_skid_register_if.sv
// Valid/ready handshake bundle for the skid register.
// master: producer/consumer side (bench); slave: the register.
interface pipeline_skid_register_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipeline_skid_register.sv
// Two-entry skid register: main (head) + skid, flush with drop counter.
// Ports: clk, reset (async high), flush, bus (slave), occupancy, flush_drop_count.
module pipeline_skid_register #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipeline_skid_register_if.slave bus,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] flush_drop_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int SW = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state;
  logic [WIDTH-1:0]     main_q;
  logic [WIDTH-1:0]     skid_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [1:0]           occ_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 accept;
  logic                 drain;
  logic [1:0]           drop;
  logic [SW-1:0]        sum;
  logic [CNT_WIDTH-1:0] cnt_next;

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  // A beat drained in the flush cycle was delivered, so it is not dropped.
  assign drop = occ_q + {1'b0, accept} - {1'b0, drain};
  assign sum  = {2'b00, cnt_q} + {{(SW-2){1'b0}}, drop};

  always_comb begin
    cnt_next = sum[CNT_WIDTH-1:0];
    if (sum > {2'b00, CNT_MAX}) begin
      cnt_next = CNT_MAX;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = main_q;
  assign occupancy         = occ_q;
  assign flush_drop_count  = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      cnt_q       <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      cnt_q       <= cnt_next;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state       <= ONE;
            main_q      <= bus.in_data;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        ONE: begin
          unique case (1'b1)
            (accept & drain): begin
              main_q <= bus.in_data;
            end
            (accept & ~drain): begin
              state      <= TWO;
              skid_q     <= bus.in_data;
              in_ready_q <= 1'b0;
              occ_q      <= 2'd2;
            end
            (~accept & drain): begin
              // Clear head so out_data reads 0 while empty.
              state       <= EMPTY;
              main_q      <= '0;
              out_valid_q <= 1'b0;
              occ_q       <= 2'd0;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (drain) begin
            state      <= ONE;
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd1;
          end
        end
        default: begin
          state       <= EMPTY;
          main_q      <= '0;
          skid_q      <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipeline_skid_register.md
PIPELINE_SKID_REGISTER -- requirements
Module: pipeline_skid_register

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits (legal range 1..1024).
REQ-002 Parameter CNT_WIDTH, default 8, width of the flush-drop counter.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear; discards every held beat and any beat accepted in the same cycle.
REQ-006 in_valid  input  1  upstream beat valid.
REQ-007 in_ready  output  1  register can accept a beat this cycle; driven only from state.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  downstream accepts the beat this cycle.
REQ-011 out_data  output  WIDTH  head payload; driven directly from the main register.
REQ-012 occupancy  output  2  beats held, 0..2.
REQ-013 flush_drop_count  output  CNT_WIDTH  saturating count of beats discarded by flush.

Function
REQ-014 Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-015 Storage: main register (head) plus one skid register.
REQ-016 FSM states: EMPTY (occupancy 0), ONE (occupancy 1), TWO (occupancy 2).
REQ-017 Outputs per state: in_ready = 1 in EMPTY and ONE, 0 in TWO; out_valid = 1 in ONE and TWO.
REQ-018 EMPTY: accept -> ONE, main <= in_data; otherwise hold.
REQ-019 ONE: accept & drain -> ONE, main <= in_data.
REQ-020 ONE: accept & !drain -> TWO, skid <= in_data.
REQ-021 ONE: !accept & drain -> EMPTY; neither accept nor drain -> hold.
REQ-022 TWO: drain -> ONE, main <= skid; otherwise hold (no accept possible).
REQ-023 Latency: a beat accepted at edge N appears on out_data/out_valid after edge N (one cycle).
REQ-024 Throughput: 1 beat/cycle sustained when out_ready stays high.
REQ-025 Ordering: beats leave in acceptance order; no duplication or loss except by flush.
REQ-026 Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged.
REQ-027 flush has priority over every other event: next state EMPTY; main and skid <= 0.
REQ-028 Flush drop count: on a flush edge, flush_drop_count += occupancy + accept, saturating at 2^CNT_WIDTH-1.
REQ-029 Flush and drain in the same cycle: the drained beat counts as delivered and is excluded from the drop count.
REQ-030 Beats drained while flush is asserted count as delivered to the downstream consumer.
REQ-031 Payload registers do not change on edges where they are not written; out_data reads 0 whenever state is EMPTY.

Reset
REQ-032 While reset is asserted: state EMPTY, main = 0, skid = 0, occupancy = 0, out_valid = 0, in_ready = 1, flush_drop_count = 0, all immediately and without waiting for clk.
REQ-033 Reset asserted mid-operation discards all held beats without incrementing flush_drop_count.
REQ-034 After reset deasserts, the first rising edge may accept a beat.

Verification
REQ-035 Case 1 (WIDTH=32, out_ready=1): stream 0x11,0x22,0x33 on consecutive cycles -> each beat appears one cycle later, in_ready stays 1, occupancy stays at most 1.
REQ-036 Case 2 (back-pressure): out_ready=0, offer 0xA1,0xA2,0xA3 -> 0xA1 and 0xA2 accepted, in_ready=0, occupancy=2, out_data holds 0xA1; raise out_ready -> 0xA1,0xA2,0xA3 delivered in order.
REQ-037 Case 3 (flush): occupancy=2 and in_valid=0, pulse flush -> next cycle occupancy=0, out_valid=0, out_data=0, flush_drop_count=2.
REQ-038 Case 4 (flush with accept): occupancy=1, in_valid=1, flush=1, out_ready=0 -> flush_drop_count increases by 2 and state is EMPTY.
REQ-039 Case 5 (saturation): CNT_WIDTH=2, repeat flush with occupancy=2 three times -> flush_drop_count=3 and stays there.
REQ-040 Case 6 (async reset): occupancy=2, assert reset between clock edges -> out_valid=0, in_ready=1, occupancy=0 before the next edge.
